bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
- Sequential multi-digit BCD-to-binary converter; the inverse path of the existing binary-to-BCD/7-segment display chain.
- Converts a packed DIGITS-digit BCD value, e.g. from a keypad entry or from decimal counter cascades, into a plain binary word.
- Uses reverse double-dabble: one shift-right plus per-digit correction per clock, with a start/busy/done handshake.
- Sits between decimal entry logic and binary arithmetic/counter loads, e.g. the d input of cb4cled_v-style counters.

Parameters:
- DIGITS, 4, number of BCD digits in bcd input.
- BW, 14, binary output width; must satisfy 2^BW >= 10^DIGITS. Integrator keeps BW = ceil(DIGITS*log2(10)); 14 for 4 digits.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  request conversion; sampled only in IDLE.
- bcd  input  4*DIGITS  packed BCD; digit 0 is bcd[3:0], the least significant digit.
- busy  output  1  high while a conversion is in progress (CONV state).
- done  output  1  single-cycle pulse when bin/err are updated.
- bin  output  BW  converted result; holds its value until the next done.
- err  output  1  set with done if any input digit > 9; holds until the next done.

Behaviour:
- Reset (clr=1, async): state=IDLE, busy=0, done=0, err=0, bin=0, count=0, working registers=0. Reset mid-conversion aborts it; no done is produced.
- States: IDLE, CONV, DONE.
- IDLE:
  - start=0: stay in IDLE.
  - start=1 with all digits <= 9: load shift register S = {bcd, BW'b0} (width 4*DIGITS+BW), count=0, go to CONV.
  - start=1 with any digit > 9: go to DONE with result bin=0, err=1; no CONV cycles.
- CONV, each clock:
  - S = S >> 1 (logical, zero fill).
  - Then for each digit field of the upper 4*DIGITS bits: if the digit >= 8, subtract 3.
  - count++. When count == BW-1 (i.e. on the BW-th shift), go to DONE with result bin = S[BW-1:0] after that shift, err=0.
- DONE: done=1 for exactly one cycle; bin/err update on the same edge done rises. Next state is always IDLE. start is ignored in DONE.
- Latency: start sampled at edge 0 → done=1 after edge BW+1 (15 for the defaults). Invalid input: done after edge 1.
- Throughput: one conversion per BW+2 cycles, since start is accepted again in the cycle after done.
- busy=1 only in CONV. start asserted while busy or in DONE is ignored; no queuing.
- bcd is sampled only at load; input changes during CONV have no effect.
- Per-digit correction is combinational on the shifted value within the same cycle. All outputs are registered.
- Result is exact for all valid inputs 0..10^DIGITS-1. The upper BCD part of S is zero at completion (assertion for verification).

Decomposition:
- Shared package/include (bcd_pkg): state encodings S_IDLE=2'd0, S_CONV=2'd1, S_DONE=2'd2; BCD_MAX=4'd9; function is_bcd_digit_valid.
- Sub-module bcd_rdd_cell: combinational, ports di[3:0] and o[3:0]; o = (di>=8) ? di-3 : di. Instantiated DIGITS times via generate.
- Top-level contains the FSM, counter, shift register and output registers.

Test Plan:
- After clr: bcd=16'h0000, start pulse → done at edge 15, bin=14'd0, err=0, busy high for edges 1..14.
- bcd=16'h9999, start → bin=14'd9999 (14'h270F), err=0. Then bcd=16'h1234 → bin=14'h04D2. Then bcd=16'h0001 → bin=1.
- bcd=16'h12A4 (digit 1 invalid), start → done after edge 1, err=1, bin=0, busy never high. A following valid 16'h0042 → err=0, bin=42.
- Start asserted continuously with changing bcd during CONV → only the first value is converted; next conversion starts the cycle after done; done pulses exactly one cycle each.
- clr pulsed at edge 7 of a 16'h5678 conversion → all outputs 0 immediately, state IDLE, no done. A restart converts 16'h5678 → 14'd5678.
- Randomized DIGITS=2/BW=7 and default configs over all valid inputs → bin == decimal value, compared against a reference model.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encodings and digit helpers for the BCD-to-binary converter
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd_digit_valid(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_rdd_cell.sv
// rtl/bcd_rdd_cell.sv - reverse double-dabble digit correction (subtract 3 when digit >= 8)
module bcd_rdd_cell (
    input  logic [3:0] di,
    output logic [3:0] o
);

    assign o = (di >= 4'd8) ? di - 4'd3 : di;

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential multi-digit BCD-to-binary converter, one shift per clock
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BW     = 14
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BW-1:0]         bin,
    output logic                  err
);

    localparam int SW = 4*DIGITS + BW;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BW - 1);

    state_t          state, state_nx;
    logic [SW-1:0]   sr, sr_shift, sr_fix;
    logic [CW-1:0]   count;
    logic [BW-1:0]   res_bin;
    logic            res_err;
    logic            all_valid;

    always_comb begin
        all_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit_valid(bcd[4*i +: 4]))
                all_valid = 1'b0;
        end
    end

    // Shift first, then correct every BCD field of the shifted value in the same cycle.
    assign sr_shift = sr >> 1;
    assign sr_fix[BW-1:0] = sr_shift[BW-1:0];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_cell
            bcd_rdd_cell u_cell (
                .di (sr_shift[BW + 4*g +: 4]),
                .o  (sr_fix[BW + 4*g +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = all_valid ? S_CONV : S_DONE;
            S_CONV:  if (count == LAST) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The result is staged in res_* and published one cycle later together with done.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sr      <= '0;
            count   <= '0;
            res_bin <= '0;
            res_err <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin     <= '0;
            err     <= 1'b0;
        end else begin
            busy <= (state_nx == S_CONV);
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                bin <= res_bin;
                err <= res_err;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (all_valid) begin
                            sr    <= {bcd, {BW{1'b0}}};
                            count <= '0;
                        end else begin
                            res_bin <= '0;
                            res_err <= 1'b1;
                        end
                    end
                end
                S_CONV: begin
                    sr    <= sr_fix;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        res_bin <= sr_fix[BW-1:0];
                        res_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - scoreboard bench for bcd2bin_seq, default and 2-digit configurations
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bcd = '0;
    logic        busy, done, err;
    logic [13:0] bin;

    logic        start_s = 1'b0;
    logic [7:0]  bcd_s = '0;
    logic        busy_s, done_s, err_s;
    logic [6:0]  bin_s;

    int pass = 0;
    int total = 0;

    logic [14:0] sb[$];
    logic [7:0]  sb_s[$];
    logic        prev_done = 1'b0;
    logic        prev_done_s = 1'b0;

    always #5 clk = ~clk;

    bcd2bin_seq #(.DIGITS(4), .BW(14)) dut (
        .clk(clk), .clr(clr), .start(start), .bcd(bcd),
        .busy(busy), .done(done), .bin(bin), .err(err)
    );

    bcd2bin_seq #(.DIGITS(2), .BW(7)) dut_s (
        .clk(clk), .clr(clr), .start(start_s), .bcd(bcd_s),
        .busy(busy_s), .done(done_s), .bin(bin_s), .err(err_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (done) begin
            check("done_single", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [14:0] e;
                e = sb.pop_front();
                check("bin", {18'd0, bin}, {18'd0, e[13:0]});
                check("err", {31'd0, err}, {31'd0, e[14]});
            end
        end
        prev_done = done;
    end

    always @(negedge clk) begin
        if (done_s) begin
            check("done_single_s", {31'd0, prev_done_s}, 32'd0);
            if (sb_s.size() == 0) begin
                check("unexpected_done_s", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = sb_s.pop_front();
                check("bin_s", {25'd0, bin_s}, {25'd0, e[6:0]});
                check("err_s", {31'd0, err_s}, {31'd0, e[7]});
            end
        end
        prev_done_s = done_s;
    end

    // Counts negedges after the sampling edge until done; k = index of the edge done followed.
    task automatic wait_done(input int exp_lat, input int exp_busy, input string tag);
        int k, nb;
        k = 0;
        nb = 0;
        while (k < 40) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) break;
            k++;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_busy_cycles"}, nb, exp_busy);
    endtask

    task automatic run_conv(input logic [15:0] v, input logic [13:0] eb, input logic ee);
        @(posedge clk); #1;
        bcd = v;
        start = 1'b1;
        sb.push_back({ee, eb});
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(ee ? 1 : 15, ee ? 0 : 14, "conv");
    endtask

    task automatic run_small(input logic [7:0] v, input logic [6:0] eb, input logic ee);
        int k;
        @(posedge clk); #1;
        bcd_s = v;
        start_s = 1'b1;
        sb_s.push_back({ee, eb});
        @(posedge clk); #1;
        start_s = 1'b0;
        k = 0;
        while (k < 30) begin
            @(negedge clk);
            if (done_s) break;
            k++;
        end
        check("small_latency", k, ee ? 1 : 8);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_bin",  {18'd0, bin}, 0);
        check("rst_err",  {31'd0, err}, 0);
        clr = 1'b0;

        run_conv(16'h0000, 14'd0, 1'b0);
        run_conv(16'h9999, 14'd9999, 1'b0);
        run_conv(16'h1234, 14'h04D2, 1'b0);
        run_conv(16'h0001, 14'd1, 1'b0);
        run_conv(16'h12A4, 14'd0, 1'b1);
        run_conv(16'h0042, 14'd42, 1'b0);
        run_conv(16'hF000, 14'd0, 1'b1);

        // start held high with bcd changing during CONV: only load-time values are converted
        @(posedge clk); #1;
        bcd = 16'h1111;
        start = 1'b1;
        sb.push_back({1'b0, 14'd1111});
        @(posedge clk); #1;
        bcd = 16'h3333;
        wait_done(15, 14, "hold1");
        bcd = 16'h0777;
        sb.push_back({1'b0, 14'd777});
        @(posedge clk); #1;
        start = 1'b0;
        bcd = 16'h4444;
        wait_done(15, 14, "hold2");

        // abort a conversion with clr after edge 6
        @(posedge clk); #1;
        bcd = 16'h5678;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_bin",  {18'd0, bin}, 0);
        check("abort_err",  {31'd0, err}, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (20) @(negedge clk);
        run_conv(16'h5678, 14'd5678, 1'b0);

        for (int v = 0; v < 10000; v += 37)
            run_conv(to_bcd(v), 14'(v), 1'b0);
        run_conv(16'h9998, 14'd9998, 1'b0);

        for (int t = 0; t < 10; t++)
            for (int o = 0; o < 10; o++)
                run_small({4'(t), 4'(o)}, 7'(t * 10 + o), 1'b0);
        run_small(8'h9B, 7'd0, 1'b1);
        run_small(8'h99, 7'd99, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("sb_s_empty", sb_s.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
